// File: rtl/rx_ppe_stm1_rsp.sv
// Shared table memory 1 responder for the RX PPE: one per-chunk write port and
// two exact-match read ports, 288-bit words stored verbatim as four 72-bit chunks.
module rx_ppe_stm1_rsp #(
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 2 ** ADDR_W,
  parameter int RD_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   tbl_wen,
  input  logic [1:0][3:0]              tbl_ren,
  input  logic [2:0][ADDR_W-1:0]       tbl_addr,
  input  logic [287:0]                 tbl_wdata,
  output logic [1:0][287:0]            tbl_em_rdata,
  output logic                         oor_err,
  output logic [15:0]                  oor_cnt
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // There is no valid/ready handshake: a read sampled at edge N is presented on
  // tbl_em_rdata from edge N+RD_LAT, and the requester counts on that latency.

  logic              wr_ok;
  logic [1:0][3:0]   rd_en_d;
  logic [1:0][3:0]   rd_en_q;
  logic [1:0][IDX_W-1:0] rd_idx_q;
  logic [1:0][287:0] rd_data;
  logic [1:0][287:0] pipe_q [RD_LAT];

  assign wr_ok = in_range(tbl_addr[0]);

  always_comb begin
    rd_en_d = '0;
    for (int e = 0; e < 2; e++) begin
      rd_en_d[e] = tbl_ren[e] & {4{in_range(tbl_addr[e+1])}};
    end
  end

  // Address stage: out-of-range or disabled chunks are dropped here so the
  // data stage simply forces them to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q  <= '0;
      rd_idx_q <= '0;
    end else begin
      rd_en_q <= rd_en_d;
      for (int e = 0; e < 2; e++) begin
        rd_idx_q[e] <= tbl_addr[e+1][IDX_W-1:0];
      end
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_chunk
    logic [71:0] mem_q [DEPTH];

    // Array is deliberately unreset; the write commits at the edge so a read
    // addressed at the same edge picks it up from the array a cycle later.
    always_ff @(posedge clk) begin
      if (rst_n && tbl_wen[c] && wr_ok) begin
        mem_q[tbl_addr[0][IDX_W-1:0]] <= tbl_wdata[72*c +: 72];
      end
    end

    for (genvar e = 0; e < 2; e++) begin : g_port
      assign rd_data[e][72*c +: 72] = rd_en_q[e][c] ? mem_q[rd_idx_q[e]] : 72'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= rd_data;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tbl_em_rdata = pipe_q[RD_LAT-1];

  logic [2:0]  oor_ev;
  logic [1:0]  oor_sum;
  logic [16:0] cnt_sum;
  logic [15:0] oor_cnt_d;
  logic [15:0] oor_cnt_q;
  logic        oor_err_d;
  logic        oor_err_q;

  always_comb begin
    oor_ev    = '0;
    oor_ev[0] = (|tbl_wen) && !in_range(tbl_addr[0]);
    oor_ev[1] = (|tbl_ren[0]) && !in_range(tbl_addr[1]);
    oor_ev[2] = (|tbl_ren[1]) && !in_range(tbl_addr[2]);
    oor_sum   = {1'b0, oor_ev[0]} + {1'b0, oor_ev[1]} + {1'b0, oor_ev[2]};
    cnt_sum   = {1'b0, oor_cnt_q} + 17'(oor_sum);
    oor_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    oor_err_d = oor_err_q | (oor_sum != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_cnt_q <= '0;
      oor_err_q <= 1'b0;
    end else begin
      oor_cnt_q <= oor_cnt_d;
      oor_err_q <= oor_err_d;
    end
  end

  assign oor_cnt = oor_cnt_q;
  assign oor_err = oor_err_q;

endmodule

// File: tb/tb_rx_ppe_stm1_rsp.sv
// Directed bench for rx_ppe_stm1_rsp: driver pushes expected read data into a
// queue, a posedge monitor pops and compares; OOR counters checked each cycle.
module tb_rx_ppe_stm1_rsp;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [3:0]             tbl_wen = '0;
  logic [1:0][3:0]        tbl_ren = '0;
  logic [2:0][ADDR_W-1:0] tbl_addr = '0;
  logic [287:0]           tbl_wdata = '0;
  logic [1:0][287:0]      tbl_em_rdata;
  logic                   oor_err;
  logic [15:0]            oor_cnt;

  always #5 clk = ~clk;

  rx_ppe_stm1_rsp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .tbl_wen(tbl_wen), .tbl_ren(tbl_ren),
    .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_em_rdata(tbl_em_rdata),
    .oor_err(oor_err), .oor_cnt(oor_cnt)
  );

  int           checks = 0;
  int           failures = 0;
  logic [575:0] exp_q[$];
  bit           mon_en = 1'b0;
  logic [71:0]  mdl[int];
  logic [15:0]  exp_cnt = '0;
  logic         exp_err = 1'b0;

  task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [287:0] model_read(input logic [3:0] ren, input logic [10:0] a);
    logic [287:0] r;
    r = '0;
    if (a < 11'd1024) begin
      for (int c = 0; c < 4; c++) begin
        if (ren[c] && mdl.exists(int'(a) * 4 + c)) r[72*c +: 72] = mdl[int'(a) * 4 + c];
      end
    end
    return r;
  endfunction

  function automatic logic [287:0] pat(input int i);
    logic [287:0] r;
    for (int c = 0; c < 4; c++) r[72*c +: 72] = {8'(c), 32'(i), 32'hDEAD_0000 + 32'(i)};
    return r;
  endfunction

  // One clock cycle of stimulus; also checks counters from all earlier cycles.
  task automatic drive(input logic [3:0] wen, input logic [10:0] wa, input logic [287:0] wd,
                       input logic [3:0] r0, input logic [10:0] a0,
                       input logic [3:0] r1, input logic [10:0] a1);
    int n;
    int s;
    @(negedge clk);
    chk("oor_cnt", 576'(oor_cnt), 576'(exp_cnt));
    chk("oor_err", 576'(oor_err), 576'(exp_err));
    tbl_wen = wen; tbl_addr[0] = wa; tbl_wdata = wd;
    tbl_ren[0] = r0; tbl_addr[1] = a0;
    tbl_ren[1] = r1; tbl_addr[2] = a1;
    if (wa < 11'd1024) begin
      for (int c = 0; c < 4; c++) if (wen[c]) mdl[int'(wa) * 4 + c] = wd[72*c +: 72];
    end
    exp_q.push_back({model_read(r1, a1), model_read(r0, a0)});
    n = 0;
    if (wen != 0 && wa >= 11'd1024) n++;
    if (r0 != 0 && a0 >= 11'd1024) n++;
    if (r1 != 0 && a1 >= 11'd1024) n++;
    s = int'(exp_cnt) + n;
    exp_cnt = (s > 65535) ? 16'hFFFF : 16'(s);
    if (n != 0) exp_err = 1'b1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(4'h0, 11'h0, '0, 4'h0, 11'h0, 4'h0, 11'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    tbl_wen = '0; tbl_ren = '0; tbl_addr = '0; tbl_wdata = '0;
    #1;
    chk("rst_rdata", tbl_em_rdata, '0);
    chk("rst_oor_cnt", 576'(oor_cnt), '0);
    chk("rst_oor_err", 576'(oor_err), '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_rdata", tbl_em_rdata, '0);
    end
    exp_q.delete();
    for (int i = 0; i < RD_LAT + 1; i++) exp_q.push_back('0);
    exp_cnt = '0;
    exp_err = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL em_rdata_underflow actual=empty required=entry");
      end else begin
        chk("em_rdata", tbl_em_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [287:0] part;
    do_reset();

    // basic write then read one cycle later
    drive(4'hF, 11'h100, {36{8'hA5}}, 4'h0, 11'h0, 4'h0, 11'h0);
    drive(4'h0, 11'h0, '0, 4'hF, 11'h100, 4'h0, 11'h0);
    idle(3);

    // partial chunk write and partial read
    drive(4'hF, 11'd5, {4{72'h1}}, 4'h0, 11'h0, 4'h0, 11'h0);
    part = 288'(72'hFF) << 144;
    drive(4'b0100, 11'd5, part, 4'h0, 11'h0, 4'h0, 11'h0);
    drive(4'h0, 11'h0, '0, 4'b0110, 11'd5, 4'b0110, 11'd5);
    idle(2);

    // write-first collision, then per-chunk collision
    drive(4'hF, 11'd7, {4{72'h3}}, 4'h0, 11'h0, 4'h0, 11'h0);
    idle(1);
    drive(4'h1, 11'd7, 288'(72'hC), 4'h1, 11'd7, 4'h1, 11'd7);
    drive(4'h1, 11'd7, 288'(72'hD), 4'b0011, 11'd7, 4'hF, 11'd7);
    idle(2);

    // back-to-back reads on both ports
    for (int i = 0; i < 16; i++) drive(4'hF, 11'h200 + 11'(i), pat(i), 4'h0, 11'h0, 4'h0, 11'h0);
    for (int i = 0; i < 16; i++)
      drive(4'h0, 11'h0, '0, 4'hF, 11'h200 + 11'(i), 4'hF, 11'h20F - 11'(i));
    idle(3);

    // out-of-range write must not alias onto 976
    drive(4'hF, 11'd976, {4{72'h5A5A}}, 4'h0, 11'h0, 4'h0, 11'h0);
    drive(4'hF, 11'd2000, '1, 4'hF, 11'd1500, 4'h0, 11'h0);
    drive(4'h0, 11'h0, '0, 4'hF, 11'd976, 4'h0, 11'h0);
    idle(2);

    // drive the count up to 16'hFFFE, then saturate
    for (int i = 0; i < 30000 && exp_cnt < 16'hFFFE; i++)
      drive(4'hF, 11'd2000, '0, 4'hF, 11'd1500, 4'hF, 11'd1800);
    idle(1);
    drive(4'hF, 11'd2000, '0, 4'hF, 11'd1500, 4'hF, 11'd1800);
    idle(1);
    drive(4'hF, 11'd2000, '0, 4'hF, 11'd1500, 4'hF, 11'd1800);
    idle(2);

    // reset while a read is in flight; stored data survives
    drive(4'h0, 11'h0, '0, 4'hF, 11'h100, 4'hF, 11'd5);
    do_reset();
    idle(3);
    drive(4'h0, 11'h0, '0, 4'hF, 11'h100, 4'hF, 11'd7);
    idle(RD_LAT + 2);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_ppe_stm1_rsp.md
# rx_ppe_stm1_rsp

Responder end of the RX PPE to shared table memory 1 link: accepts per-chunk writes on port 0 and serves two exact-match (EM) read ports with a fixed, pipelined read latency. Stores 288-bit words (4 chunks of 72 bits, ECC included) verbatim, with no ECC check or generation. Sits in the shared table memory block, facing the RX PPE table-lookup logic.

## Interface
Parameters:
- ADDR_W, 17, address width per port.
- DEPTH, 2**ADDR_W, entries per chunk. Addresses >= DEPTH are out of range.
- RD_LAT, 2, read latency in cycles from ren/addr sample to rdata valid. Legal range 1..4.

Ports:
- clk  input  1  sole clock, all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- tbl_wen  input  [3:0]  per-chunk write enables, port 0.
- tbl_ren  input  [1:0][3:0]  per-EM-port, per-chunk read enables. Index 0 is EM port 1; index 1 is EM port 2.
- tbl_addr  input  [2:0][ADDR_W-1:0]  addr[0] is the write address; addr[1] and addr[2] are the EM read addresses.
- tbl_wdata  input  [287:0]  write data. Chunk c is bits [72c+71:72c].
- tbl_em_rdata  output  [1:0][287:0]  EM read data. Index e serves addr[e+1].
- oor_err  output  1  sticky: any enabled access to an out-of-range address.
- oor_cnt  output  [15:0]  saturating count of out-of-range enabled accesses.

## Operation
- Storage: 4 independent chunk arrays, each DEPTH x 72. The array is not reset; contents survive rst_n assertion.
- Write: each cycle, for every c with tbl_wen[c]=1 and addr[0] < DEPTH, write wdata chunk c into chunk array c at addr[0]. Chunks with wen=0 are untouched.
- Read: for EM port e and chunk c with tbl_ren[e][c]=1, read chunk array c at addr[e+1].
  - The result appears in tbl_em_rdata[e] chunk c exactly RD_LAT cycles later.
  - A chunk with ren=0 returns 72'h0 in its result slot.
  - An out-of-range read returns 72'h0.
  - The two EM ports are fully independent and may hit the same address.
- Write/read collision, same cycle, same address, same chunk: write-first. The read returns the new wdata chunk. Collisions on different chunks of the same address are resolved per chunk.
- Out-of-range handling: count one event per port per cycle that has any enable set and an out-of-range address, so up to 3 events per cycle. Add the per-cycle sum to oor_cnt and saturate at 16'hFFFF. Set oor_err when the sum is nonzero.
- Reset (rst_n low):
  - tbl_em_rdata, the read pipeline, oor_err and oor_cnt all clear to 0 immediately.
  - In-flight reads are discarded and never appear after reset release.
  - Writes and reads are ignored while rst_n is low.

## Timing
- Write visibility:
  - A write committed at edge N is visible to a read sampled at edge N+1.
  - A read sampled at edge N itself gets the new data through the write-first bypass.
- Read pipeline: sample ren/addr at edge N, array read, then RD_LAT-1 register stages. Data drives tbl_em_rdata from edge N+RD_LAT until the next pipeline update.
- Output behaviour:
  - tbl_em_rdata is registered output, updated every cycle.
  - With no reads issued it returns to 0 RD_LAT cycles after the last ren.
- Throughput: one write plus two reads every cycle with no stalls. There is no handshake; the PPE relies on the fixed RD_LAT.
- Counters:
  - oor_err and oor_cnt update one cycle after the offending access.
  - oor_cnt saturates: at 16'hFFFF it holds and does not wrap.
- After rst_n deasserts, the first sample edge is the first rising clk edge with rst_n high. Outputs stay 0 until RD_LAT cycles after the first read.

## Test plan
- Basic write/read:
  - Stimulus: write wdata=288'hA5..A5 with wen=4'hF at addr 0x100. Next cycle, ren[0]=4'hF at addr[1]=0x100.
  - Required: rdata[0]=wdata exactly RD_LAT cycles later, and rdata[1]=0.
- Partial chunk:
  - Stimulus: write all chunks with 72'h1 at addr 5, then wen=4'b0100 with chunk 2=72'hFF. Then read with ren=4'b0110.
  - Required: chunk 1=72'h1, chunk 2=72'hFF, chunks 0 and 3=0.
- Collision:
  - Stimulus: same cycle, write addr 7 chunk 0=72'hC, with both EM ports reading addr 7 chunk 0. Old value was 72'h3.
  - Required: both ports return 72'hC.
- Back-to-back:
  - Stimulus: 16 consecutive reads on both ports to distinct addresses.
  - Required: 16 consecutive correct results, each RD_LAT after issue, with no gaps.
- Out-of-range:
  - Stimulus (DEPTH=1024): wen=4'hF at addr 2000, and a read on port 1 at addr 1500 in the same cycle.
  - Required: no array change, read returns 0, oor_cnt=2, and oor_err=1 the next cycle.
  - Stimulus: force the count to 16'hFFFE, then one cycle with 3 OOR accesses.
  - Required: oor_cnt=16'hFFFF.
- Reset mid-read:
  - Stimulus: issue a read, assert rst_n low one cycle later, then release.
  - Required: tbl_em_rdata=0 throughout and no stale data after release.
  - Follow-up: a subsequent read of the previously written address returns the retained data.
